// File: rtl/uart_tx_fifo_if.sv
// FIFO read-side handshake between a show-ahead synchronous FIFO and the
// UART transmitter that drains it.
//   fifo_empty : FIFO empty flag (FIFO -> transmitter)
//   fifo_data  : FIFO head word, valid while fifo_empty=0 (FIFO -> transmitter)
//   fifo_rd    : one-cycle pop strobe (transmitter -> FIFO)
// Modports: master = FIFO side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned W = 8
);
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rd;

  modport master (output fifo_empty, output fifo_data, input fifo_rd);
  modport slave  (input fifo_empty, input fifo_data, output fifo_rd);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter that drains a show-ahead FIFO: pops one word whenever the
// FIFO is non-empty and the transmitter is idle, then sends start bit, W data
// bits LSB-first, optional even parity bit, and STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset
//   fifo    : FIFO read handshake (slave modport of uart_tx_fifo_if)
//   tx      : serial line, idle high, registered
//   busy    : high while a frame is in progress
//   tx_done : one-cycle pulse on the last cycle of the final stop bit
module uart_tx_fifo #(
  parameter int unsigned W            = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_fifo_if.slave   fifo,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic [W-1:0]  shift, shift_n;
  logic          tx_n, busy_n, tx_done_n;
  logic          bit_end;
  logic          pop_c;
`ifdef UART_TX_PARITY_EN
  logic          parity, parity_n;
`endif

  // Pop only from IDLE; suppressed during reset so the FIFO never sees a
  // pop that the transmitter will not act on.
  assign pop_c        = (state == IDLE) & ~fifo.fifo_empty & ~reset;
  assign fifo.fifo_rd = pop_c;
  assign bit_end      = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
      busy     <= busy_n;
      tx_done  <= tx_done_n;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_n;
`endif
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + BW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
`ifdef UART_TX_PARITY_EN
    parity_n = parity;
`endif

    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (pop_c) begin
          shift_n = fifo.fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_n = ^fifo.fifo_data;
`endif
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == CW'(W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
            bit_n = '0;
          end else begin
            bit_n = bit_cnt + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
`endif
      STOP: begin
        // bit_cnt counts stop bits here
        if (bit_end) begin
          if (bit_cnt == CW'(STOP_BITS - 1)) begin
            state_n = IDLE;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);

    // One cycle early so the registered pulse lands on the final stop cycle
    tx_done_n = (state == STOP) && (bit_cnt == CW'(STOP_BITS - 1)) &&
                (baud_cnt == BW'(CLKS_PER_BIT - 2));
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (W=8, CLKS_PER_BIT=4,
// STOP_BITS=1). Expected line bits are queued when a word is offered to the
// transmitter and popped as the serial frame is observed.
module tb_uart_tx_fifo;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned SB  = 1;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy, tx_done;

  int   ncmp  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  logic exp_q[$];

  uart_tx_fifo_if #(.W(W)) bus ();

  uart_tx_fifo #(
    .W(W), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .fifo(bus.slave),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a pop strobe; returns the cycle it was seen in
  task automatic wait_rd(output int rd_cyc);
    logic found;
    found = 1'b0;
    #1;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.fifo_rd === 1'b1) found = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk("rd_seen", found, 1'b1);
    rd_cyc = cyc;
  endtask

  // Expect one complete frame of word d; after the pop, drive the FIFO
  // inputs to nxt_empty/nxt_data.
  task automatic frame(input logic [W-1:0] d, input logic nxt_empty,
                       input logic [W-1:0] nxt_data, output int rd_cyc);
    int   nb;
    logic e;
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
    nb = exp_q.size();
    wait_rd(rd_cyc);
    @(negedge clk);
    bus.fifo_empty = nxt_empty;
    bus.fifo_data  = nxt_data;
    chk("rd_one_cycle", bus.fifo_rd, 1'b0);
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < int'(CPB); c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        chk("tx_bit", tx, e);
        chk("busy", busy, 1'b1);
        chk("tx_done", tx_done, (b == nb - 1) && (c == int'(CPB) - 1));
      end
    end
    @(negedge clk);
    chk("busy_idle", busy, 1'b0);
    chk("tx_done_end", tx_done, 1'b0);
    chk("tx_idle", tx, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0, r1, r2;

    // Reset held with a non-empty FIFO
    reset = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd", bus.fifo_rd, 1'b0);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
    end

    // Empty FIFO after reset: nothing happens
    bus.fifo_empty = 1'b1;
    reset = 1'b0;
    repeat (200) begin
      @(negedge clk);
      chk("empty_rd", bus.fifo_rd, 1'b0);
      chk("empty_tx", tx, 1'b1);
      chk("empty_busy", busy, 1'b0);
    end

    // Single word 0xA5
    bus.fifo_data  = 8'hA5;
    bus.fifo_empty = 1'b0;
    frame(8'hA5, 1'b1, 8'h00, r0);

    // Back-to-back 0x00 then 0xFF; data changes mid-frame must not matter
    @(negedge clk);
    bus.fifo_data  = 8'h00;
    bus.fifo_empty = 1'b0;
    frame(8'h00, 1'b0, 8'hFF, r1);
    frame(8'hFF, 1'b1, 8'h00, r2);
    chk_int("rd_gap", r2 - r1, 41);

    // Reset during data bit 3 of 0x3C, then a fresh 0x81 frame
    @(negedge clk);
    bus.fifo_data  = 8'h3C;
    bus.fifo_empty = 1'b0;
    wait_rd(r0);
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    repeat (17) @(negedge clk);
    chk("abort_bit3", tx, 1'b1);
    chk("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    bus.fifo_data  = 8'h81;
    bus.fifo_empty = 1'b0;
    #1;
    chk("abort_rd_in_reset", bus.fifo_rd, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    frame(8'h81, 1'b1, 8'h00, r0);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    bus.fifo_data  = 8'h07;
    bus.fifo_empty = 1'b0;
    frame(8'h07, 1'b1, 8'h00, r0);
    @(negedge clk);
    bus.fifo_data  = 8'h03;
    bus.fifo_empty = 1'b0;
    frame(8'h03, 1'b1, 8'h00, r0);
`endif

    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
